// File: rtl/rr_grant_controller.sv
// Round-robin grant controller for N requesters with a request/done handshake.
// It gives one-hot grants, caps each grant at MAX_HOLD cycles, and forces one idle cycle between grants.
module rr_grant_controller #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    parameter int IW       = 3,
    parameter int CW       = 4,
    parameter int HW       = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  reqs_i,
    input  logic [N-1:0]  done_i,
    output logic [N-1:0]  grants_o,
    output logic          busy_o,
    output logic [IW-1:0] owner_o,
    output logic          timeout_o,
    output logic [CW-1:0] cnt_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grants_q, grants_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;

    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic          rel_done, rel_drop, at_limit;

    // Scan offsets from N down to 1 so the nearest requester after last_q wins.
    // Index arithmetic wraps naturally at IW bits because N is a power of two.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = N; k >= 1; k--) begin
            cand = last_q + IW'(k);
            if (reqs_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++)
            cnt_o = cnt_o + CW'(reqs_i[i]);
    end

    assign rel_done = done_i[owner_q];
    assign rel_drop = ~reqs_i[owner_q];
    assign at_limit = (hold_q == HW'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        grants_d  = grants_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                grants_d = '0;
                busy_d   = 1'b0;
                if (pick_vld) begin
                    grants_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d  = pick_idx;
                    busy_d   = 1'b1;
                    hold_d   = HW'(1);
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || at_limit) begin
                    grants_d  = '0;
                    busy_d    = 1'b0;
                    last_d    = owner_q;
                    hold_d    = '0;
                    state_d   = IDLE;
                    // Report a timeout only when the hold limit alone forced the release.
                    timeout_d = at_limit && !rel_done && !rel_drop;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grants_q  <= '0;
            owner_q   <= '0;
            last_q    <= IW'(N - 1);
            hold_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grants_q  <= grants_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grants_o  = grants_q;
    assign busy_o    = busy_q;
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

endmodule

// File: doc/rr_grant_controller.md
Name: rr_grant_controller

Overview:
Sequential round-robin controller that shares one resource among N requesters using a request/done handshake. A requester keeps its one-hot grant until it signals completion, drops its request, or exhausts a maximum hold time. Round-robin priority advances past each released owner, so all-active requesters are served in strict rotation. It sits between the requesting agents and the shared resource's enable/select inputs.

Parameters:
N, 8, number of requesters (power of two, 2..16)
MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant (>=2)
IW, 3, owner index width, equal to log2(N)
CW, 4, pending-count width, equal to log2(N)+1
HW, 5, hold counter width, enough to hold MAX_HOLD

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
reqs_i  in  N  request vector, bit i = requester i wants the resource
done_i  in  N  completion pulse; only the bit of the current owner is honoured
grants_o  out  N  registered one-hot grant, or all zeros
busy_o  out  1  registered; high while any grant is asserted
owner_o  out  IW  registered index of current/last owner
timeout_o  out  1  registered one-cycle pulse when a grant is revoked by MAX_HOLD
cnt_o  out  CW  combinational popcount of reqs_i

Behaviour:
- Reset (reset=0, asynchronous): grants_o=0, busy_o=0, owner_o=0, timeout_o=0, hold counter=0, state=IDLE, last-owner pointer=N-1 so requester 0 has top priority first.
- State IDLE: at each rising edge, if reqs_i!=0, pick the first set bit searching from (last+1) mod N upward with wrap-around.
  - Load grants_o with that one-hot, owner_o with its index, busy_o=1, hold counter=1, go to GRANT.
  - Latency is one edge from request sampled to grant visible.
  - If reqs_i=0, stay in IDLE with outputs at zero (owner_o holds).
- State GRANT: release at the edge where any of the following holds:
  - done_i[owner]=1
  - reqs_i[owner]=0
  - hold counter==MAX_HOLD
- On release: grants_o=0, busy_o=0, last-owner pointer=owner, hold counter=0, go to IDLE. Otherwise keep the grant and increment the hold counter.
- Maximum grant duration is exactly MAX_HOLD cycles.
- Guaranteed turnaround: at least one cycle of grants_o=0 between consecutive grants, including re-grant to the same requester.
- timeout_o=1 for the single cycle following a release caused solely by the hold limit. If done_i[owner] or the owner's request drop coincides with the limit, timeout_o stays 0.
- done_i bits of non-owners, and done_i while IDLE, are ignored.
- Requests from other agents during GRANT never preempt the owner.
- grants_o is never multi-hot; busy_o always equals |grants_o.
- Reset asserted mid-grant: all outputs drop immediately without waiting for a clock, and the pointer returns to N-1.
- cnt_o is purely combinational and valid every cycle, including during reset.
- Fairness: with all N requesting and no done pulses, the grant order is 0,1,…,N-1,0 with MAX_HOLD cycles each.

Test Plan:
1. Reset released, reqs_i=0x00 for 4 cycles -> grants_o=0x00, busy_o=0, cnt_o=0, timeout_o=0 throughout.
2. reqs_i=0x01, done_i[0] pulsed on the 3rd grant cycle -> grants_o=0x01 one edge after request, held 3 cycles, 0x00 on the next edge; cnt_o=1.
3. reqs_i=0xFF, each owner pulses done after 1 grant cycle -> grants sequence 0x01,0,0x02,0,0x04,…,0x80,0,0x01; cnt_o=8; owner_o tracks 0..7.
4. reqs_i=0x08 held, no done -> grants_o=0x08 for exactly 16 cycles, timeout_o=1 for one cycle, one idle cycle, then re-grant 0x08.
5. Owner 1 releases via done, reqs_i=0x0A -> next grant is 0x08, not 0x02. With done_i and the hold limit in the same cycle -> release with timeout_o=0.
6. reset driven low mid-grant with grants_o=0x10 -> grants_o=0 and busy_o=0 before the next edge. After release with reqs_i=0xFF -> first grant 0x01.
